// File: rtl/counter_ctrl.sv
// Run/pause/step sequencer driving the enable/upDown inputs of a 4-bit up/down counter.
// A free-running prescaler paces RUN; ping-pong mode bounces between lo and hi using count feedback.
module counter_ctrl #(
    parameter int PRESCALE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [1:0] mode,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    input  logic [3:0] count,
    output logic       enable,
    output logic       upDown,
    output logic [1:0] state,
    output logic       busy
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          enable_q, enable_d;
    logic          ud_q, ud_d;

    logic          cnt_evt;
    logic          eff_dir;
    logic          pulse_ok;

    // Effective direction for a count event; pulse_ok drops on a degenerate ping-pong range.
    always_comb begin
        eff_dir  = 1'b1;
        pulse_ok = 1'b1;
        case (mode)
            2'b01: eff_dir = 1'b0;
            2'b10: begin
                if (lo >= hi) begin
                    pulse_ok = 1'b0;
                    eff_dir  = dir_q;
                end else if (dir_q && (count >= hi)) begin
                    eff_dir = 1'b0;
                end else if (!dir_q && (count <= lo)) begin
                    eff_dir = 1'b1;
                end else begin
                    eff_dir = dir_q;
                end
            end
            default: eff_dir = 1'b1;
        endcase
    end

    // Command decode: stop beats start beats step, one command per cycle.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_evt = 1'b0;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end else if (step) begin
                    cnt_evt = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    cnt_evt = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    dir_d   = (mode != 2'b01);
                end else if (start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end else if (step) begin
                    cnt_evt = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enable_d = 1'b0;
        ud_d     = ud_q;
        if (cnt_evt && pulse_ok) begin
            enable_d = 1'b1;
            ud_d     = eff_dir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            dir_q    <= 1'b1;
            enable_q <= 1'b0;
            ud_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            dir_q    <= (cnt_evt && pulse_ok) ? eff_dir : dir_d;
            enable_q <= enable_d;
            ud_q     <= ud_d;
        end
    end

    assign enable = enable_q;
    assign upDown = ud_q;
    assign state  = state_q;
    assign busy   = (state_q == S_RUN);

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl with a behavioural 4-bit counter closing the count feedback loop.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       step  = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [3:0] lo    = 4'd0;
    logic [3:0] hi    = 4'd0;
    logic [3:0] count;
    logic       enable;
    logic       upDown;
    logic [1:0] state;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int ud;
        int cnt;
    } exp_t;

    exp_t sbq[$];
    logic pend_chk = 1'b0;
    int   pend_cnt = 0;

    counter_ctrl #(.PRESCALE(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .step  (step),
        .mode  (mode),
        .lo    (lo),
        .hi    (hi),
        .count (count),
        .enable(enable),
        .upDown(upDown),
        .state (state),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= 4'd0;
        else if (enable) count <= upDown ? count + 4'd1 : count - 4'd1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int c, input int ud, input int cnt);
        exp_t e;
        e.cyc = c;
        e.ud  = ud;
        e.cnt = cnt;
        sbq.push_back(e);
    endfunction

    // Every observed pulse must match the head of the queue in cycle and direction.
    always @(negedge clk) begin
        exp_t e;
        if (pend_chk) begin
            chk("count_after", int'(count), pend_cnt);
            pend_chk = 1'b0;
        end
        if (enable === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_pulse", int'(enable), 0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_cyc", cyc, e.cyc);
                chk("pulse_dir", int'(upDown), e.ud);
                if (e.cnt >= 0) begin
                    pend_cnt = e.cnt;
                    pend_chk = 1'b1;
                end
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive_start(output int c);
        c = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int pp_cnt[12] = '{1, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4};
        int pp_ud[12]  = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};

        rst = 1'b0;
        #1 rst = 1'b1;
        #10 rst = 1'b0;
        @(negedge clk);

        // Reset / idle
        repeat (100) @(negedge clk);
        chk("idle_state", int'(state), 0);
        chk("idle_updown", int'(upDown), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_enable", int'(enable), 0);
        chk("idle_count", int'(count), 0);
        drive_stop();
        chk("idle_stop_noeffect", int'(state), 0);

        // Run up through the 15->0 wrap, then stop at count 5
        mode = 2'b00;
        drive_start(c);
        chk("run_busy", int'(busy), 1);
        chk("run_state", int'(state), 1);
        for (int k = 1; k <= 21; k++) push_exp(c + 1 + 10 * k, 1, k % 16);
        wait_cyc(c + 212);
        drive_stop();
        chk("pause_state", int'(state), 2);
        chk("pause_busy", int'(busy), 0);
        repeat (50) @(negedge clk);
        chk("pause_hold_count", int'(count), 5);
        chk("sb_run_up", sbq.size(), 0);

        // Resume: first pulse 10 cycles after the start edge
        drive_start(c);
        push_exp(c + 11, 1, 6);
        wait_cyc(c + 12);
        drive_stop();
        chk("resume_pause", int'(state), 2);

        // Step from PAUSE in down mode
        mode = 2'b01;
        c = cyc;
        push_exp(c + 1, 0, 5);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_step", sbq.size(), 0);
        chk("step_state", int'(state), 2);

        // Step ignored in RUN; stop on a tick cycle suppresses the pulse
        mode = 2'b00;
        drive_start(c);
        push_exp(c + 11, 1, 6);
        wait_cyc(c + 3);
        step = 1'b1;
        wait_cyc(c + 7);
        step = 1'b0;
        wait_cyc(c + 20);
        drive_stop();
        chk("collision_state", int'(state), 2);
        repeat (15) @(negedge clk);
        chk("collision_count", int'(count), 6);
        chk("sb_collision", sbq.size(), 0);
        drive_stop();
        chk("pause_to_idle", int'(state), 0);

        // Async reset while a pulse is in flight
        drive_start(c);
        push_exp(c + 11, 1, -1);
        wait_cyc(c + 11);
        #2;
        chk("enable_before_rst", int'(enable), 1);
        rst = 1'b1;
        #1;
        chk("rst_enable", int'(enable), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_updown", int'(upDown), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        #4 rst = 1'b0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("sb_rst", sbq.size(), 0);

        // Ping-pong between 2 and 5
        mode = 2'b10;
        lo = 4'd2;
        hi = 4'd5;
        drive_start(c);
        for (int k = 1; k <= 12; k++) push_exp(c + 1 + 10 * k, pp_ud[k-1], pp_cnt[k-1]);
        wait_cyc(c + 122);
        drive_stop();
        chk("pp_pause", int'(state), 2);
        drive_stop();
        repeat (3) @(negedge clk);
        chk("sb_pingpong", sbq.size(), 0);
        chk("pp_idle", int'(state), 0);

        // Degenerate range: prescaler runs, no pulses
        lo = 4'd3;
        hi = 4'd3;
        drive_start(c);
        repeat (60) @(negedge clk);
        chk("degen_state", int'(state), 1);
        chk("degen_busy", int'(busy), 1);
        chk("degen_count", int'(count), 4);
        drive_stop();
        drive_stop();
        chk("degen_idle", int'(state), 0);
        repeat (3) @(negedge clk);
        chk("sb_final", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run/pause/step sequencer for the 4-bit up/down counter. It converts operator commands into the counter's `enable` and `upDown` inputs, and paces counting with an internal prescaler. It supports up, down and ping-pong modes, with ping-pong bouncing between programmable limits. It sits between the button/switch inputs and the counter + 7-segment decoder, and reads back `count` to decide ping-pong turnarounds.

## Interface
- `PRESCALE`, default 10: clock cycles between enable pulses in RUN. Legal range is ≥ 2.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level, sampled each cycle; enter/resume RUN.
- `stop` in 1: level, sampled each cycle; RUN→PAUSE, PAUSE→IDLE.
- `step` in 1: level, sampled each cycle; one enable pulse when not running.
- `mode` in 2: 00 up, 01 down, 10 ping-pong, 11 treated as up.
- `lo` in 4: ping-pong lower limit.
- `hi` in 4: ping-pong upper limit.
- `count` in 4: current counter value, fed back from the counter.
- `enable` out 1: to counter; one-cycle pulse per count event.
- `upDown` out 1: to counter; 1 = up, 0 = down.
- `state` out 2: 00 IDLE, 01 RUN, 10 PAUSE.
- `busy` out 1: high when `state` = RUN.

## Operation
- Reset values: `state` = IDLE, `enable` = 0, `upDown` = 1, `busy` = 0, prescaler = 0, direction register `dir` = 1.
- Command priority within a cycle is `stop` > `start` > `step`; only one command acts per cycle.
- IDLE:
  - `start` → RUN, prescaler cleared.
  - `step` → one pulse.
  - `stop` → no effect.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps; the cycle it equals PRESCALE-1 is a tick.
  - `stop` → PAUSE, prescaler frozen.
  - `start` and `step` ignored.
- PAUSE:
  - `start` → RUN, prescaler cleared.
  - `step` → one pulse.
  - `stop` → IDLE, and `dir` reloaded (0 if `mode` = 01, else 1).
- Count event (a tick in RUN, or an accepted step) computes the effective direction `d`:
  - mode up: `d` = 1.
  - mode down: `d` = 0.
  - mode ping-pong:
    - `dir` = 1 and `count` ≥ `hi` → `d` = 0.
    - `dir` = 0 and `count` ≤ `lo` → `d` = 1.
    - otherwise `d` = `dir`.
- On a count event: `enable` <= 1 for exactly one cycle, `upDown` <= `d`, `dir` <= `d`.
- Ping-pong with `lo` ≥ `hi` is a degenerate range: no pulse is issued; the prescaler and state still advance normally.
- Up/down modes rely on the counter's natural 4-bit wrap (15→0, 0→15); no limits are applied.
- Mode changes take effect at the next count event. `upDown` holds its last value between events.
- `step` held high produces one pulse per cycle while not in RUN. Debouncing and edge detection are upstream.

## Timing
- `enable` and `upDown` are registered.
- Tick/step decision is made in cycle N; `enable` is high in cycle N+1; the counter updates at the end of N+1.
- Prescaler alignment:
  - First RUN pulse appears PRESCALE cycles after the `start` edge.
  - Subsequent pulses are exactly PRESCALE cycles apart.
  - `busy` rises the cycle after `start` is sampled.
- `stop` sampled in the same cycle as a tick: the stop wins and no pulse is issued.
- PRESCALE ≥ 2 guarantees `count` reflects the previous pulse before the next decision.
- Asynchronous reset mid-operation:
  - All outputs go to reset values immediately, including cancelling a pulse in flight.
  - The counter is reset by the same `rst`.

## Test plan
- Reset/idle: `rst` high 10 ns, release, no commands for 100 cycles → `state` = 00, `enable` never high, `upDown` = 1, count stays 0.
- Run up: `mode` = 00, `start` one cycle, PRESCALE = 10 → first pulse 10 cycles later, then one every 10 cycles; count 0,1,2,…,15,0 with seg7 0000001, 1001111, 0010010, … as counts pass.
- Pause/resume: `stop` at count 5 → `state` = 10 and count holds 5 for 50 cycles; `start` → pulse 10 cycles later, count 6.
- Step: from PAUSE, `step` for 1 cycle in `mode` = 01 → exactly one pulse with `upDown` = 0, count 6→5; `step` while in RUN → no extra pulse.
- Ping-pong: `lo` = 2, `hi` = 5, start at count 0 → count sequence 1,2,3,4,5,4,3,2,3,4,5,4; `upDown` flips on the pulse leaving 5 and the pulse leaving 2. With `lo` = `hi` = 3 → no pulses.
- Collisions: `stop` asserted on a tick cycle → no pulse, `state` = PAUSE. Async `rst` asserted mid-RUN while `enable` is high → `enable` drops immediately, `state` = 00, `upDown` = 1.
